// File: rtl/sync_modn_counter_if.sv
// Control and status bundle for the mod-N counter.
// The master drives the controls; the slave (the counter) returns the count and its flags.
interface sync_modn_counter_if #(
  parameter int unsigned MOD    = 10,
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned DW = $clog2(MOD);

  logic                   en;
  logic                   up;
  logic                   clr;
  logic                   load;
  logic [DIGITS*DW-1:0]   load_val;
  logic [DIGITS*DW-1:0]   q;
  logic                   tc;
  logic                   wrap;

  modport master (output en, up, clr, load, load_val, input q, tc, wrap);
  modport slave  (input en, up, clr, load, load_val, output q, tc, wrap);
endinterface

// File: rtl/sync_modn_counter.sv
// DIGITS cascaded mod-MOD digits with enable, up/down, sync clear, saturating parallel load,
// combinational terminal count and a registered wrap pulse. Carries ripple within one cycle.
module sync_modn_counter #(
  parameter int unsigned MOD    = 10,
  parameter int unsigned DIGITS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  sync_modn_counter_if.slave    bus
);
  localparam int unsigned DW = $clog2(MOD);
  localparam logic [DW-1:0] MAXD = DW'(MOD - 1);

  logic [DIGITS-1:0][DW-1:0] q_r;
  logic [DIGITS-1:0][DW-1:0] q_nxt;
  logic [DIGITS-1:0][DW-1:0] ld_sat;
  logic                      wrap_r;
  logic                      tc_c;
  logic                      carry;

  // Per-digit step logic; carry means every lower digit is terminal for the current direction.
  // An out-of-range digit counts as terminal-in-up so a corrupted state flushes back to 0.
  always_comb begin
    carry  = 1'b1;
    q_nxt  = q_r;
    ld_sat = '0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      logic          t_up;
      logic          t_dn;
      logic [DW-1:0] ld;
      t_up = (q_r[k] >= MAXD);
      t_dn = (q_r[k] == '0);
      if (carry) begin
        if (bus.up) q_nxt[k] = t_up ? '0 : q_r[k] + DW'(1);
        else        q_nxt[k] = (t_dn || (q_r[k] > MAXD)) ? MAXD : q_r[k] - DW'(1);
      end
      carry     = carry & (bus.up ? t_up : t_dn);
      ld        = bus.load_val[k*DW +: DW];
      ld_sat[k] = (ld > MAXD) ? MAXD : ld;
    end
    tc_c = bus.en & carry;
  end

  // Priority: reset > clr > load > en; wrap marks a whole-counter rollover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else if (bus.clr) begin
      q_r    <= '0;
      wrap_r <= 1'b0;
    end else if (bus.load) begin
      q_r    <= ld_sat;
      wrap_r <= 1'b0;
    end else if (bus.en) begin
      q_r    <= q_nxt;
      wrap_r <= tc_c;
    end else begin
      wrap_r <= 1'b0;
    end
  end

  assign bus.q    = q_r;
  assign bus.tc   = tc_c;
  assign bus.wrap = wrap_r;
endmodule

// File: tb/tb_sync_modn_counter.sv
// Bench for sync_modn_counter: vector table, directed corner sequences and random stimulus
// against an integer-valued reference model; extra instances cover MOD=16/DIGITS=3 and MOD=2/DIGITS=1.
module tb_sync_modn_counter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sync_modn_counter_if #(.MOD(10), .DIGITS(2)) m ();
  sync_modn_counter_if #(.MOD(16), .DIGITS(3)) h ();
  sync_modn_counter_if #(.MOD(2),  .DIGITS(1)) b ();

  sync_modn_counter #(.MOD(10), .DIGITS(2)) dut   (.clk(clk), .reset(reset), .bus(m));
  sync_modn_counter #(.MOD(16), .DIGITS(3)) dut16 (.clk(clk), .reset(reset), .bus(h));
  sync_modn_counter #(.MOD(2),  .DIGITS(1)) dut2  (.clk(clk), .reset(reset), .bus(b));

  int vectors = 0;
  int miscompares = 0;
  int mv = 0;       // model count as a plain integer 0..99
  bit mw = 1'b0;    // model wrap flag

  typedef struct {
    bit         en, up, clr, load;
    logic [7:0] lv;
    logic [7:0] exp_q;
    bit         exp_tc, exp_wrap;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic int sat9(input logic [3:0] d);
    return (int'(d) > 9) ? 9 : int'(d);
  endfunction

  function automatic logic [7:0] to_q(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  task automatic drive(input bit e, input bit u, input bit c, input bit l, input logic [7:0] lv);
    m.en = e; m.up = u; m.clr = c; m.load = l; m.load_val = lv;
  endtask

  // One clock of the MOD=10 instance checked against the integer model.
  task automatic mcycle(input bit e, input bit u, input bit c, input bit l, input logic [7:0] lv);
    bit etc;
    drive(e, u, c, l, lv);
    @(negedge clk);
    etc = e && (u ? (mv == 99) : (mv == 0));
    chk("tc", 32'(m.tc), 32'(etc));
    if (c) begin
      mv = 0; mw = 1'b0;
    end else if (l) begin
      mv = sat9(lv[7:4]) * 10 + sat9(lv[3:0]); mw = 1'b0;
    end else if (e) begin
      mv = u ? (mv + 1) % 100 : (mv + 99) % 100; mw = etc;
    end else begin
      mw = 1'b0;
    end
    @(posedge clk); #1;
    chk("q", 32'(m.q), 32'(to_q(mv)));
    chk("wrap", 32'(m.wrap), 32'(mw));
  endtask

  task automatic hcycle(input bit e, input bit l, input logic [11:0] lv,
                        input logic [11:0] eq, input bit etc, input bit ew);
    h.en = e; h.up = 1'b1; h.clr = 1'b0; h.load = l; h.load_val = lv;
    @(negedge clk);
    chk("tc16", 32'(h.tc), 32'(etc));
    @(posedge clk); #1;
    chk("q16", 32'(h.q), 32'(eq));
    chk("wrap16", 32'(h.wrap), 32'(ew));
  endtask

  task automatic bcycle(input logic eq, input bit etc, input bit ew);
    b.en = 1'b1; b.up = 1'b1; b.clr = 1'b0; b.load = 1'b0; b.load_val = 1'b0;
    @(negedge clk);
    chk("tc2", 32'(b.tc), 32'(etc));
    @(posedge clk); #1;
    chk("q2", 32'(b.q), 32'(eq));
    chk("wrap2", 32'(b.wrap), 32'(ew));
  endtask

  vec_t tbl[$];

  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    h.en = 1'b0; h.up = 1'b1; h.clr = 1'b0; h.load = 1'b0; h.load_val = '0;
    b.en = 1'b0; b.up = 1'b1; b.clr = 1'b0; b.load = 1'b0; b.load_val = '0;

    // Reset held for five cycles
    repeat (5) @(posedge clk);
    #1;
    chk("rst_q", 32'(m.q), 32'h0);
    chk("rst_wrap", 32'(m.wrap), 32'h0);
    chk("rst_tc_up", 32'(m.tc), 32'h0);
    m.en = 1'b1; m.up = 1'b0; #1;
    chk("rst_tc_dn", 32'(m.tc), 32'h1);
    m.en = 1'b0; m.up = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;

    // Full up cycle 00..99..00
    mv = 0; mw = 1'b0;
    for (int i = 0; i < 100; i++) mcycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Load 57 then count down through 00 -> 99
    mcycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h57);
    for (int i = 0; i < 59; i++) mcycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

    // Vector table: saturating load, priority, carry, hold, direction change, rollovers
    mcycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tbl = '{
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'hA3, 8'h93, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b1, 1'b1, 8'h55, 8'h00, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'h09, 8'h09, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h10, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h09, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'h99, 8'h99, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h99, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h98, 1'b0, 1'b0},
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 8'h99, 1'b0, 1'b0},
      '{1'b1, 1'b1, 1'b0, 1'b1, 8'h12, 8'h12, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0}
    };
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].up, tbl[i].clr, tbl[i].load, tbl[i].lv);
      @(negedge clk);
      chk($sformatf("tbl%0d_tc", i), 32'(m.tc), 32'(tbl[i].exp_tc));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_q", i), 32'(m.q), 32'(tbl[i].exp_q));
      chk($sformatf("tbl%0d_wrap", i), 32'(m.wrap), 32'(tbl[i].exp_wrap));
    end
    mv = 0; mw = 1'b0;

    // Asynchronous reset between edges while counting at 42
    mcycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h41);
    mcycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_q", 32'(m.q), 32'h0);
    chk("async_wrap", 32'(m.wrap), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    mv = 0; mw = 1'b0;
    mcycle(1'b1, 1'b1, 1'b0, 1'b0, 8'h00);

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      bit e, u, c, l;
      logic [7:0] lv;
      e  = ($urandom_range(99, 0) < 75);
      u  = 1'($urandom_range(1, 0));
      c  = ($urandom_range(99, 0) < 4);
      l  = ($urandom_range(99, 0) < 8);
      lv = 8'($urandom);
      mcycle(e, u, c, l, lv);
    end

    // Hex three-digit instance: rollover from 0xFFE
    hcycle(1'b0, 1'b1, 12'hFFE, 12'hFFE, 1'b0, 1'b0);
    hcycle(1'b1, 1'b0, 12'h000, 12'hFFF, 1'b0, 1'b0);
    hcycle(1'b1, 1'b0, 12'h000, 12'h000, 1'b1, 1'b1);
    hcycle(1'b0, 1'b0, 12'h000, 12'h000, 1'b0, 1'b0);

    // Binary single-digit instance toggling
    bcycle(1'b1, 1'b0, 1'b0);
    bcycle(1'b0, 1'b1, 1'b1);
    bcycle(1'b1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
